// File: rtl/handshake_constant_burst.sv
// -----------------------------------------------------------------------------
// handshake_constant_burst
//
// Elastic constant source. Every control token accepted on the ctrl channel
// makes the block emit REPEAT tokens on outs. Each of those tokens carries the
// fixed VALUE. The output valid comes from a register, so a control token
// accepted in cycle N shows up on outs_valid in cycle N+1. There is no
// combinational path from ctrl_valid to outs_valid.
//
// Parameters
//   DATA_WIDTH : width of outs
//   VALUE      : constant driven on outs, truncated or zero-extended to
//                DATA_WIDTH
//   REPEAT     : output tokens per control token, 1..65535
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   ctrl_valid : control token present
//   ctrl_ready : control token accepted when ctrl_valid & ctrl_ready
//   outs       : constant data, always VALUE
//   outs_valid : output token present
//   outs_ready : downstream accepts the token
//   tok_count  : 16-bit count of emitted tokens, wraps
//                (present only when HSCONST_TOKEN_COUNT_EN is defined)
//
// Build option
//   HSCONST_TOKEN_COUNT_EN : adds the tok_count port and its counter.
// -----------------------------------------------------------------------------
module handshake_constant_burst #(
  parameter int unsigned      DATA_WIDTH = 32,
  parameter longint unsigned  VALUE      = 0,
  parameter int unsigned      REPEAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HSCONST_TOKEN_COUNT_EN
  ,
  output logic [15:0]           tok_count
`endif
);

  localparam int unsigned CW = $clog2(REPEAT + 1);

  localparam logic [DATA_WIDTH-1:0] VALUE_C  = DATA_WIDTH'(VALUE);
  localparam logic [CW-1:0]         REPEAT_C = CW'(REPEAT);
  localparam logic [CW-1:0]         ONE_C    = CW'(1);

  generate
    if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
      $error("handshake_constant_burst: REPEAT must be in 1..65535");
    end
  endgenerate

  // Number of output tokens still owed for the current burst.
  logic [CW-1:0] pending_q;
  logic [CW-1:0] pending_d;
  logic          ofire;
  logic          cfire;

  assign outs       = VALUE_C;
  assign outs_valid = (pending_q != '0);

  // A new control token may also be taken on the cycle that drains the last
  // owed token. This lets bursts run back to back with no bubble. The only
  // combinational input here is outs_ready (plus rst).
  assign ctrl_ready = !rst && ((pending_q == '0) ||
                               ((pending_q == ONE_C) && outs_ready));

  assign ofire = outs_valid && outs_ready;
  assign cfire = ctrl_valid && ctrl_ready;

  // cfire wins. When it coincides with the final ofire, the counter re-arms
  // straight to REPEAT.
  always_comb begin
    pending_d = pending_q;
    if (cfire) begin
      pending_d = REPEAT_C;
    end else if (ofire) begin
      pending_d = pending_q - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifdef HSCONST_TOKEN_COUNT_EN
  logic [15:0] tok_count_q;
  logic [15:0] tok_count_d;

  // Wraps naturally from 16'hFFFF to 16'h0000.
  always_comb begin
    tok_count_d = tok_count_q + {15'd0, ofire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_count_q <= '0;
    end else begin
      tok_count_q <= tok_count_d;
    end
  end

  assign tok_count = tok_count_q;
`endif

endmodule

// File: tb/tb_handshake_constant_burst.sv
module tb_handshake_constant_burst;

  localparam logic [11:0] VAL = 12'h5AE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // REPEAT = 1 instance
  logic        cv1, cr1, ov1, or1;
  logic [11:0] outs1;
  // REPEAT = 3 instance
  logic        cv3, cr3, ov3, or3;
  logic [11:0] outs3;
  // REPEAT = 4 instance
  logic        cv4, cr4, ov4, or4;
  logic [11:0] outs4;
`ifdef HSCONST_TOKEN_COUNT_EN
  logic [15:0] tc1, tc3, tc4;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  handshake_constant_burst #(.DATA_WIDTH(12), .VALUE(12'h5AE), .REPEAT(1)) u_r1 (
    .clk(clk), .rst(rst), .ctrl_valid(cv1), .ctrl_ready(cr1),
    .outs(outs1), .outs_valid(ov1), .outs_ready(or1)
`ifdef HSCONST_TOKEN_COUNT_EN
    , .tok_count(tc1)
`endif
  );

  handshake_constant_burst #(.DATA_WIDTH(12), .VALUE(12'h5AE), .REPEAT(3)) u_r3 (
    .clk(clk), .rst(rst), .ctrl_valid(cv3), .ctrl_ready(cr3),
    .outs(outs3), .outs_valid(ov3), .outs_ready(or3)
`ifdef HSCONST_TOKEN_COUNT_EN
    , .tok_count(tc3)
`endif
  );

  handshake_constant_burst #(.DATA_WIDTH(12), .VALUE(12'h5AE), .REPEAT(4)) u_r4 (
    .clk(clk), .rst(rst), .ctrl_valid(cv4), .ctrl_ready(cr4),
    .outs(outs4), .outs_valid(ov4), .outs_ready(or4)
`ifdef HSCONST_TOKEN_COUNT_EN
    , .tok_count(tc4)
`endif
  );

  // Reset held 3 cycles with ctrl_valid high, then first token after release.
  task automatic test_reset();
    rst = 1'b1;
    cv1 = 1'b1; cv3 = 1'b1; cv4 = 1'b1;
    or1 = 1'b0; or3 = 1'b0; or4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ov1 !== 1'b0 || ov3 !== 1'b0 || ov4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_outs_valid cyc%0d: got %b%b%b expected 000", i, ov1, ov3, ov4);
      end
      tests_run++;
      if (cr1 !== 1'b0 || cr3 !== 1'b0 || cr4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ctrl_ready cyc%0d: got %b%b%b expected 000", i, cr1, cr3, cr4);
      end
      tests_run++;
      if (outs1 !== VAL || outs3 !== VAL || outs4 !== VAL) begin
        tests_failed++;
        $display("FAIL reset_outs cyc%0d: got %h/%h/%h expected %h", i, outs1, outs3, outs4, VAL);
      end
    end
    rst = 1'b0; cv3 = 1'b0; cv4 = 1'b0; cv1 = 1'b1;
    #1;
    tests_run++;
    if (cr1 !== 1'b1 || ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_accept: got cr=%b ov=%b expected cr=1 ov=0", cr1, ov1);
    end
    @(posedge clk); #1;
    cv1 = 1'b0;
    tests_run++;
    if (ov1 !== 1'b1 || outs1 !== VAL) begin
      tests_failed++;
      $display("FAIL post_reset_latency: got ov=%b outs=%h expected ov=1 outs=%h", ov1, outs1, VAL);
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_drain: got ov=%b expected 0", ov1);
    end
    or1 = 1'b0;
    $display("[TB] test_reset done");
  endtask

  // REPEAT=1, ctrl_valid and outs_ready held high for 10 cycles.
  task automatic test_repeat1_stream();
    int nc = 0;
    int no = 0;
    for (int i = 1; i <= 10; i++) begin
      cv1 = 1'b1; or1 = 1'b1;
      #1;
      tests_run++;
      if (cr1 !== 1'b1 || ov1 !== (i >= 2)) begin
        tests_failed++;
        $display("FAIL stream cyc%0d: got cr=%b ov=%b expected cr=1 ov=%b", i, cr1, ov1, (i >= 2));
      end
      if (cv1 && cr1) nc++;
      if (ov1 && or1) no++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (nc != 10 || no != 9) begin
      tests_failed++;
      $display("FAIL stream_counts: got cfires=%0d ofires=%0d expected 10/9", nc, no);
    end
    cv1 = 1'b0;
    #1;
    tests_run++;
    if (ov1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_last: got ov=%b expected 1", ov1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_idle: got ov=%b expected 0", ov1);
    end
    or1 = 1'b0;
    $display("[TB] test_repeat1_stream cfires=%0d ofires=%0d", nc, no);
  endtask

  // REPEAT=3, one ctrl token, outs_ready high.
  task automatic test_burst3();
    bit t_cv [5] = '{1, 0, 0, 0, 0};
    bit t_ov [5] = '{0, 1, 1, 1, 0};
    bit t_cr [5] = '{1, 0, 0, 1, 1};
    int no = 0;
    for (int i = 0; i < 5; i++) begin
      cv3 = t_cv[i]; or3 = 1'b1;
      #1;
      tests_run++;
      if (ov3 !== t_ov[i] || cr3 !== t_cr[i] || outs3 !== VAL) begin
        tests_failed++;
        $display("FAIL burst3 cyc%0d: got ov=%b cr=%b outs=%h expected ov=%b cr=%b outs=%h",
                 i, ov3, cr3, outs3, t_ov[i], t_cr[i], VAL);
      end
      if (ov3 && or3) no++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (no != 3) begin
      tests_failed++;
      $display("FAIL burst3_tokens: got %0d expected 3", no);
    end
    cv3 = 1'b0; or3 = 1'b0;
    $display("[TB] test_burst3 tokens=%0d", no);
  endtask

  // REPEAT=3, 5-cycle stall, drain, second token accepted on final drain cycle.
  task automatic test_back_to_back();
    bit t_cv [13] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    bit t_or [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    bit t_ov [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit t_cr [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1};
    int no = 0;
    int nc = 0;
    for (int i = 0; i < 13; i++) begin
      cv3 = t_cv[i]; or3 = t_or[i];
      #1;
      tests_run++;
      if (ov3 !== t_ov[i] || cr3 !== t_cr[i]) begin
        tests_failed++;
        $display("FAIL b2b cyc%0d: got ov=%b cr=%b expected ov=%b cr=%b", i, ov3, cr3, t_ov[i], t_cr[i]);
      end
      if (ov3 && or3) no++;
      if (cv3 && cr3) nc++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (no != 6 || nc != 2) begin
      tests_failed++;
      $display("FAIL b2b_counts: got ofires=%0d cfires=%0d expected 6/2", no, nc);
    end
    cv3 = 1'b0; or3 = 1'b0;
    $display("[TB] test_back_to_back ofires=%0d cfires=%0d", no, nc);
  endtask

  // REPEAT=4, reset after 2 tokens, then a fresh burst of 4.
  task automatic test_mid_reset();
    bit t_rst [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit t_cv  [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    bit t_or  [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    bit t_ov  [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit t_cr  [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    int pre = 0;
    int post = 0;
    for (int i = 0; i < 10; i++) begin
      rst = t_rst[i]; cv4 = t_cv[i]; or4 = t_or[i];
      #1;
      tests_run++;
      if (ov4 !== t_ov[i] || cr4 !== t_cr[i] || outs4 !== VAL) begin
        tests_failed++;
        $display("FAIL midrst cyc%0d: got ov=%b cr=%b outs=%h expected ov=%b cr=%b outs=%h",
                 i, ov4, cr4, outs4, t_ov[i], t_cr[i], VAL);
      end
      if (ov4 && or4) begin
        if (i < 3) pre++;
        else post++;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    tests_run++;
    if (pre != 2 || post != 4) begin
      tests_failed++;
      $display("FAIL midrst_counts: got pre=%0d post=%0d expected 2/4", pre, post);
    end
    cv4 = 1'b0; or4 = 1'b0;
    $display("[TB] test_mid_reset pre=%0d post=%0d", pre, post);
  endtask

`ifdef HSCONST_TOKEN_COUNT_EN
  // REPEAT=1, 65537 output fires, counter wraps to 1, then reset clears it.
  task automatic test_tok_count();
    int  fires = 0;
    bit  seen_zero = 1'b0;
    rst = 1'b1; cv1 = 1'b0; or1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (tc1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL tok_count_init: got %h expected 0000", tc1);
    end
    cv1 = 1'b1; or1 = 1'b1;
    for (int cyc = 0; cyc < 70000 && fires < 65537; cyc++) begin
      #1;
      if (ov1 && or1) fires++;
      @(posedge clk); #1;
      if (fires == 65536 && !seen_zero) begin
        seen_zero = 1'b1;
        tests_run++;
        if (tc1 !== 16'd0) begin
          tests_failed++;
          $display("FAIL tok_count_wrap0: got %h expected 0000", tc1);
        end
      end
    end
    cv1 = 1'b0; or1 = 1'b0;
    #1;
    tests_run++;
    if (fires != 65537 || tc1 !== 16'd1) begin
      tests_failed++;
      $display("FAIL tok_count_wrap: got fires=%0d count=%h expected 65537/0001", fires, tc1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (tc1 !== 16'd0 || ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL tok_count_reset: got count=%h ov=%b expected 0000/0", tc1, ov1);
    end
    $display("[TB] test_tok_count fires=%0d", fires);
  endtask
`endif

  initial begin
    test_reset();
    test_repeat1_stream();
    test_burst3();
    test_back_to_back();
    test_mid_reset();
`ifdef HSCONST_TOKEN_COUNT_EN
    test_tok_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
